// File: rtl/tlm_pkg.sv
// Shared encodings for the traffic light monitor: light bus codes, phase codes,
// dwell-counter width and the legal phase-step rule.
package tlm_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    PH_NONE   = 2'b00,
    PH_RED    = 2'b01,
    PH_YELLOW = 2'b10,
    PH_GREEN  = 2'b11
  } phase_e;

  localparam int DWELL_W = 8;

  // Progress through one full GREEN->YELLOW->YELLOW->RED->GREEN round
  typedef enum logic [2:0] {
    RND_IDLE,
    RND_G,
    RND_GY,
    RND_GYY,
    RND_GYYR
  } round_e;

  function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
    return (from_ph == to_ph) ||
           (from_ph == PH_GREEN  && to_ph == PH_YELLOW) ||
           (from_ph == PH_YELLOW && to_ph == PH_RED) ||
           (from_ph == PH_RED    && to_ph == PH_GREEN);
  endfunction

endpackage

// File: rtl/tlm_dwell_counter.sv
// Saturating dwell counter: clear restarts the count (to 1 when the same cycle
// also advances), advance adds one and holds at the all-ones value.
module tlm_dwell_counter
  import tlm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [DWELL_W-1:0] count
);

  localparam logic [DWELL_W-1:0] COUNT_MAX = '1;
  localparam logic [DWELL_W-1:0] COUNT_ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = advance ? COUNT_ONE : '0;
    end else if (advance && count_q != COUNT_MAX) begin
      count_d = count_q + COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for a one-hot traffic light bus: phase decode, dwell and
// sequence checks, pedestrian walk/pending tracking and completed-round count.
// Defining TLM_STARVE_CHECK_EN adds a pending-request timer driving err_starve.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int MIN_GREEN    = 3,
  parameter int MIN_YELLOW   = 2,
  parameter int WALK_DELAY   = 1,
  parameter int MAX_PED_WAIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  lights,
  input  logic        pedestrian_button,
  output logic [1:0]  phase,
  output logic        walk,
  output logic        ped_pending,
  output logic        err_onehot,
  output logic        err_seq,
  output logic        err_dwell,
  output logic        err_starve,
  output logic [15:0] cycle_count
);

  localparam logic [DWELL_W-1:0] MIN_GREEN_C  = DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] MIN_YELLOW_C = DWELL_W'(MIN_YELLOW);
  localparam logic [DWELL_W-1:0] WALK_C       = DWELL_W'(WALK_DELAY);
  localparam logic [DWELL_W-1:0] DWELL_ONE    = DWELL_W'(1);

  phase_e             phase_q, phase_d, sample_ph;
  round_e             rnd_q, rnd_d;
  logic [DWELL_W-1:0] dwell;
  logic               onehot_ok, dwell_clear, dwell_adv;
  logic               seq_bad, dwell_bad, err_evt, btn_rise;
  logic               walk_q, walk_d, ped_q, ped_d, btn_q, btn_d;
  logic               err_onehot_q, err_onehot_d, err_seq_q, err_seq_d;
  logic               err_dwell_q, err_dwell_d;
  logic [15:0]        cycle_q, cycle_d;

  tlm_dwell_counter u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clear   (dwell_clear),
    .advance (dwell_adv),
    .count   (dwell)
  );

  always_comb begin
    sample_ph = PH_NONE;
    onehot_ok = 1'b1;
    case (lights)
      LIGHT_RED:    sample_ph = PH_RED;
      LIGHT_YELLOW: sample_ph = PH_YELLOW;
      LIGHT_GREEN:  sample_ph = PH_GREEN;
      default:      onehot_ok = 1'b0;
    endcase

    phase_d     = phase_q;
    dwell_clear = 1'b0;
    dwell_adv   = 1'b0;
    seq_bad     = 1'b0;
    dwell_bad   = 1'b0;
    // A corrupt sample freezes phase and dwell; a valid one always loads phase
    if (onehot_ok) begin
      phase_d     = sample_ph;
      dwell_adv   = 1'b1;
      dwell_clear = (sample_ph != phase_q);
      if (phase_q != PH_NONE && sample_ph != phase_q) begin
        seq_bad   = !legal_step(phase_q, sample_ph);
        dwell_bad = (phase_q == PH_GREEN  && dwell < MIN_GREEN_C) ||
                    (phase_q == PH_YELLOW && dwell < MIN_YELLOW_C);
      end
    end
    err_evt = !onehot_ok || seq_bad || dwell_bad;

    // Walk follows the dwell value being registered this cycle
    walk_d = 1'b0;
    if (!onehot_ok) begin
      walk_d = (phase_q == PH_RED) && (dwell > WALK_C);
    end else if (sample_ph == PH_RED) begin
      walk_d = dwell_clear ? (DWELL_ONE > WALK_C) : (dwell >= WALK_C);
    end

    btn_d    = pedestrian_button;
    btn_rise = pedestrian_button && !btn_q;
    ped_d    = btn_rise || (ped_q && !walk_d);

    err_onehot_d = err_onehot_q || !onehot_ok;
    err_seq_d    = err_seq_q || seq_bad;
    err_dwell_d  = err_dwell_q || dwell_bad;

    rnd_d   = rnd_q;
    cycle_d = cycle_q;
    if (err_evt) begin
      rnd_d = RND_IDLE;
    end else begin
      case (sample_ph)
        PH_GREEN: begin
          if (phase_q == PH_RED && rnd_q == RND_GYYR) cycle_d = cycle_q + 16'd1;
          rnd_d = RND_G;
        end
        PH_YELLOW: begin
          if (phase_q == PH_GREEN && rnd_q == RND_G) rnd_d = RND_GY;
          else if (phase_q == PH_YELLOW && (rnd_q == RND_GY || rnd_q == RND_GYY)) rnd_d = RND_GYY;
          else rnd_d = RND_IDLE;
        end
        PH_RED: begin
          if ((phase_q == PH_YELLOW && rnd_q == RND_GYY) ||
              (phase_q == PH_RED && rnd_q == RND_GYYR)) rnd_d = RND_GYYR;
          else rnd_d = RND_IDLE;
        end
        default: rnd_d = RND_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= PH_NONE;
      rnd_q        <= RND_IDLE;
      walk_q       <= 1'b0;
      ped_q        <= 1'b0;
      btn_q        <= 1'b0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_dwell_q  <= 1'b0;
      cycle_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      rnd_q        <= rnd_d;
      walk_q       <= walk_d;
      ped_q        <= ped_d;
      btn_q        <= btn_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_dwell_q  <= err_dwell_d;
      cycle_q      <= cycle_d;
    end
  end

`ifdef TLM_STARVE_CHECK_EN
  localparam int PED_W = $clog2(MAX_PED_WAIT + 1);
  localparam logic [PED_W-1:0] PED_LIMIT = PED_W'(MAX_PED_WAIT);
  localparam logic [PED_W-1:0] PED_ONE   = PED_W'(1);

  logic [PED_W-1:0] ped_cnt_q, ped_cnt_d;
  logic             err_starve_q, err_starve_d;

  always_comb begin
    ped_cnt_d = '0;
    if (ped_q) begin
      ped_cnt_d = (ped_cnt_q == PED_LIMIT) ? ped_cnt_q : ped_cnt_q + PED_ONE;
    end
    err_starve_d = err_starve_q || (ped_cnt_d == PED_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ped_cnt_q    <= '0;
      err_starve_q <= 1'b0;
    end else begin
      ped_cnt_q    <= ped_cnt_d;
      err_starve_q <= err_starve_d;
    end
  end

  assign err_starve = err_starve_q;
`else
  // No pending timer in this build; a negative limit is meaningless, so this is constant 0
  assign err_starve = (MAX_PED_WAIT < 0);
`endif

  assign phase       = phase_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign err_onehot  = err_onehot_q;
  assign err_seq     = err_seq_q;
  assign err_dwell   = err_dwell_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor: each stimulus cycle queues
// its hand-computed response; a monitor pops and compares one cycle later.
module tb_traffic_light_monitor;

  localparam logic [2:0] L_R   = 3'b001;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b100;
  localparam logic [2:0] L_BAD = 3'b011;
  localparam logic [1:0] P_N = 2'b00, P_R = 2'b01, P_Y = 2'b10, P_G = 2'b11;
`ifdef TLM_STARVE_CHECK_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  lights = 3'b000;
  logic        pedestrian_button = 1'b0;
  logic [1:0]  phase;
  logic        walk, ped_pending, err_onehot, err_seq, err_dwell, err_starve;
  logic [15:0] cycle_count;

  traffic_light_monitor #(
    .MIN_GREEN    (3),
    .MIN_YELLOW   (2),
    .WALK_DELAY   (1),
    .MAX_PED_WAIT (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .lights            (lights),
    .pedestrian_button (pedestrian_button),
    .phase             (phase),
    .walk              (walk),
    .ped_pending       (ped_pending),
    .err_onehot        (err_onehot),
    .err_seq           (err_seq),
    .err_dwell         (err_dwell),
    .err_starve        (err_starve),
    .cycle_count       (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [23:0] mon_act;
  int          n_cmp = 0;
  int          n_bad = 0;

  // err = {onehot, seq, dwell, starve}
  task automatic step(input string tag, input logic rst_n, input logic [2:0] l,
                      input logic b, input logic [1:0] ph, input logic w,
                      input logic pp, input logic [3:0] err, input logic [15:0] cc);
    exp_t e;
    reset             = rst_n;
    lights            = l;
    pedestrian_button = b;
    e.v   = {ph, w, pp, err, cc};
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      #1;
      mon_act = {phase, walk, ped_pending, err_onehot, err_seq, err_dwell, err_starve, cycle_count};
      n_cmp++;
      if (mon_act !== mon_e.v) begin
        n_bad++;
        $display("FAIL %s: got {phase,walk,ped,eoh,eseq,edw,est,cnt}=%b_%b_%b_%b%b%b%b_%0d required %b_%b_%b_%b_%0d",
                 mon_e.tag, mon_act[23:22], mon_act[21], mon_act[20], mon_act[19], mon_act[18],
                 mon_act[17], mon_act[16], mon_act[15:0], mon_e.v[23:22], mon_e.v[21],
                 mon_e.v[20], mon_e.v[19:16], mon_e.v[15:0]);
      end
    end
  end

  initial begin
    @(posedge clk);
    #2;

    // Full legal round with walk window
    step("A.rst", 1'b0, L_G, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.g1",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.g2",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.g3",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.g4",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.y1",  1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.y2",  1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.r1",  1'b1, L_R, 1'b0, P_R, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("A.r2",  1'b1, L_R, 1'b0, P_R, 1'b1, 1'b0, 4'b0000, 16'd0);
    step("A.r3",  1'b1, L_R, 1'b0, P_R, 1'b1, 1'b0, 4'b0000, 16'd0);
    step("A.g5",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd1);

    // Illegal YELLOW->GREEN
    step("B.rst", 1'b0, L_Y, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("B.y1",  1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("B.y2",  1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("B.g1",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0100, 16'd0);
    step("B.g2",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0100, 16'd0);

    // GREEN dwell just below and exactly at the minimum
    step("C.rst",  1'b0, L_G, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.g1",   1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.g2",   1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.ys",   1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0010, 16'd0);
    step("C.rst2", 1'b0, L_G, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.h1",   1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.h2",   1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.h3",   1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("C.yok",  1'b1, L_Y, 1'b0, P_Y, 1'b0, 1'b0, 4'b0000, 16'd0);

    // Non-one-hot glitch during RED: dwell frozen at 1, then resumes at 2
    step("D.rst", 1'b0, L_R,   1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("D.r1",  1'b1, L_R,   1'b0, P_R, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("D.bad", 1'b1, L_BAD, 1'b0, P_R, 1'b0, 1'b0, 4'b1000, 16'd0);
    step("D.r2",  1'b1, L_R,   1'b0, P_R, 1'b1, 1'b0, 4'b1000, 16'd0);

    // Pedestrian request through to walk, then a re-press coinciding with walk
    step("E.rst", 1'b0, L_G, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("E.g1",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("E.g2",  1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.g3",  1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.g4",  1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.y1",  1'b1, L_Y, 1'b1, P_Y, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.y2",  1'b1, L_Y, 1'b1, P_Y, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.y3",  1'b1, L_Y, 1'b1, P_Y, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.r1",  1'b1, L_R, 1'b1, P_R, 1'b0, 1'b1, 4'b0000, 16'd0);
    step("E.r2",  1'b1, L_R, 1'b0, P_R, 1'b1, 1'b0, 4'b0000, 16'd0);
    step("E.r3",  1'b1, L_R, 1'b1, P_R, 1'b1, 1'b1, 4'b0000, 16'd0);
    step("E.g5",  1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1, 4'b0000, 16'd1);
    step("E.rst2",1'b0, L_G, 1'b1, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("E.g6",  1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1, 4'b0000, 16'd0);

    // Long GREEN with a request held pending
    step("F.rst", 1'b0, L_G, 1'b0, P_N, 1'b0, 1'b0, 4'b0000, 16'd0);
    step("F.g0",  1'b1, L_G, 1'b0, P_G, 1'b0, 1'b0, 4'b0000, 16'd0);
    for (int i = 1; i < 40; i++) begin
      step($sformatf("F.g%0d", i), 1'b1, L_G, 1'b1, P_G, 1'b0, 1'b1,
           {3'b000, STARVE_ON && (i >= 33)}, 16'd0);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses still queued, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
